// File: rtl/memory_interface_responder_pkg.sv
// Shared definitions for the memory interface responder: request encodings,
// FSM state encoding and a byte-lane mask expansion helper.
// Imported by memory_interface_responder and memory_responder_storage.
package memory_interface_responder_pkg;

  // Request encodings on memory_interface_state / memory_interface_enable
  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // Expand a 4-bit byte-lane mask into a 32-bit bit mask
  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      r[8*n +: 8] = {8{m[n]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/memory_responder_storage.sv
// DEPTH x 32 word store with per-byte-lane writes and a registered, lane-masked read.
// Ports: clk/rst, commit strobe, word_idx, byte_we, wr_dat, rd_lane_en in; rd_dat out.
// rd_dat updates only on a commit edge (masked lanes read as zero) and holds otherwise.
module memory_responder_storage
  import memory_interface_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit,
  input  logic [ADDR_BITS-1:0] word_idx,
  input  logic [3:0]           byte_we,
  input  logic [31:0]          wr_dat,
  input  logic [3:0]           rd_lane_en,
  output logic [31:0]          rd_dat
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_dat_q;
  logic [31:0] rd_dat_d;

  // Store contents survive reset, so the array has no reset branch
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int n = 0; n < 4; n++) begin
        if (byte_we[n]) begin
          mem_q[word_idx][8*n +: 8] <= wr_dat[8*n +: 8];
        end
      end
    end
  end

  // A write commit has rd_lane_en=0, so it also returns zero read data
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (commit) begin
      rd_dat_d = mem_q[word_idx] & lane_mask(rd_lane_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/memory_interface_responder.sv
// Memory-side responder: accepts one request, completes it LATENCY cycles later with a ready pulse.
// Ports: clk, reset, memory_interface_{enable,state,address,frame_mask,write_data} in;
//        memory_interface_{read_data,ready,error} out. Optional MEMORY_RESPONDER_RANGE_CHECK_EN.
module memory_interface_responder
  import memory_interface_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_interface_enable,
  input  logic        memory_interface_state,
  input  logic [31:0] memory_interface_address,
  input  logic [3:0]  memory_interface_frame_mask,
  input  logic [31:0] memory_interface_write_data,
  output logic [31:0] memory_interface_read_data,
  output logic        memory_interface_ready,
  output logic        memory_interface_error
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_st_q, req_st_d;
  logic [ADDR_BITS-1:0] req_idx_q, req_idx_d;
  logic [3:0]           req_mask_q, req_mask_d;
  logic [31:0]          req_wdat_q, req_wdat_d;
  logic                 req_oor_q, req_oor_d;

  logic                 in_oor;
  logic                 commit;
  logic                 cur_st;
  logic [ADDR_BITS-1:0] cur_idx;
  logic [3:0]           cur_mask;
  logic [31:0]          cur_wdat;
  logic                 cur_oor;
  logic [3:0]           byte_we;
  logic [3:0]           rd_lane_en;

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
  logic err_q, err_d;
  logic unused_addr_lsb;
  assign in_oor          = (memory_interface_address[31:ADDR_BITS+2] != '0);
  assign unused_addr_lsb = ^memory_interface_address[1:0];
`else
  // Upper address bits are dropped, so addresses alias modulo DEPTH*4
  logic unused_addr_bits;
  assign in_oor           = 1'b0;
  assign unused_addr_bits = ^{memory_interface_address[31:ADDR_BITS+2],
                              memory_interface_address[1:0]};
`endif

  // With LATENCY=1 the commit happens on the acceptance edge itself,
  // so the storage is fed straight from the inputs while in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      cur_st   = memory_interface_state;
      cur_idx  = memory_interface_address[ADDR_BITS+1:2];
      cur_mask = memory_interface_frame_mask;
      cur_wdat = memory_interface_write_data;
      cur_oor  = in_oor;
    end else begin
      cur_st   = req_st_q;
      cur_idx  = req_idx_q;
      cur_mask = req_mask_q;
      cur_wdat = req_wdat_q;
      cur_oor  = req_oor_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_st_d   = req_st_q;
    req_idx_d  = req_idx_q;
    req_mask_d = req_mask_q;
    req_wdat_d = req_wdat_q;
    req_oor_d  = req_oor_q;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (memory_interface_enable == ENABLE) begin
          req_st_d   = memory_interface_state;
          req_idx_d  = memory_interface_address[ADDR_BITS+1:2];
          req_mask_d = memory_interface_frame_mask;
          req_wdat_d = memory_interface_write_data;
          req_oor_d  = in_oor;
          cnt_d      = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESPOND;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign byte_we    = (commit && cur_st == WRITE && !cur_oor) ? cur_mask : 4'b0000;
  assign rd_lane_en = (commit && cur_st == READ  && !cur_oor) ? cur_mask : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_st_q   <= READ;
      req_idx_q  <= '0;
      req_mask_q <= '0;
      req_wdat_q <= '0;
      req_oor_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_st_q   <= req_st_d;
      req_idx_q  <= req_idx_d;
      req_mask_q <= req_mask_d;
      req_wdat_q <= req_wdat_d;
      req_oor_q  <= req_oor_d;
    end
  end

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
  // Error is set or cleared at every commit and held in between
  always_comb begin
    err_d = err_q;
    if (commit) begin
      err_d = cur_oor;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign memory_interface_error = err_q;
`else
  assign memory_interface_error = 1'b0;
`endif

  memory_responder_storage #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_storage (
    .clk        (clk),
    .rst        (reset),
    .commit     (commit),
    .word_idx   (cur_idx),
    .byte_we    (byte_we),
    .wr_dat     (cur_wdat),
    .rd_lane_en (rd_lane_en),
    .rd_dat     (memory_interface_read_data)
  );

  assign memory_interface_ready = (state_q == RESPOND);

endmodule

// File: tb/tb_memory_interface_responder.sv
// Testbench: four responders (LATENCY 1,4,3,2) with a queue-based scoreboard.
// Expected responses are queued when a request is driven and checked on each ready pulse.
// Ready arrival cycle, read data and error flag are all compared against the queued entry.
module tb_memory_interface_responder;
  import memory_interface_responder_pkg::*;

  localparam int NI = 4;
  localparam int LATS [NI] = '{1, 4, 3, 2};

  logic        clk;
  logic        reset;
  logic        en    [NI];
  logic        st    [NI];
  logic [31:0] addr  [NI];
  logic [3:0]  mask  [NI];
  logic [31:0] wdat  [NI];
  logic [31:0] rdat  [NI];
  logic        rdy   [NI];
  logic        err   [NI];

  int cyc;
  int n_total;
  int n_bad;

  typedef struct {
    int          inst;
    logic [31:0] rdat;
    logic        err;
    int          rcyc;
  } exp_t;

  exp_t exp_q [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_interface_responder #(
      .DEPTH   (1024),
      .LATENCY (LATS[g])
    ) u_dut (
      .clk                         (clk),
      .reset                       (reset),
      .memory_interface_enable     (en[g]),
      .memory_interface_state      (st[g]),
      .memory_interface_address    (addr[g]),
      .memory_interface_frame_mask (mask[g]),
      .memory_interface_write_data (wdat[g]),
      .memory_interface_read_data  (rdat[g]),
      .memory_interface_ready      (rdy[g]),
      .memory_interface_error      (err[g])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && rdy[g]) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ready", 32'(g), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("resp_inst",  32'(g),       32'(e.inst));
          chk("resp_rdata", rdat[g],      e.rdat);
          chk("resp_err",   32'(err[g]),  32'(e.err));
          chk("resp_cycle", 32'(cyc),     32'(e.rcyc));
        end
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%08h want=%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_exp(input int g, input logic [31:0] rd, input logic e, input int rc);
    exp_t x;
    x.inst = g;
    x.rdat = rd;
    x.err  = e;
    x.rcyc = rc;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("ready_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // One request on instance g; inputs are scrambled and enable dropped
  // the cycle after acceptance, which must not disturb the request.
  task automatic req(input int g, input logic w, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e);
    en[g]   = ENABLE;
    st[g]   = w;
    addr[g] = a;
    mask[g] = m;
    wdat[g] = wd;
    push_exp(g, exp_rd, exp_e, cyc + LATS[g]);
    @(negedge clk);
    en[g]   = DISABLE;
    st[g]   = ~w;
    addr[g] = a ^ 32'h0000_0004;
    mask[g] = ~m;
    wdat[g] = ~wd;
    wait_drain();
  endtask

  initial begin
    cyc     = 0;
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    for (int i = 0; i < NI; i++) begin
      en[i] = DISABLE; st[i] = READ; addr[i] = '0; mask[i] = '0; wdat[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing moves
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("idle_ready", 32'(rdy[i]), 32'd0);
        chk("idle_rdata", rdat[i],     32'd0);
        chk("idle_err",   32'(err[i]), 32'd0);
      end
    end

    // LATENCY=1: full word write then read
    req(0, WRITE, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req(0, READ,  32'h10, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0);
    repeat (2) @(negedge clk);
    chk("rdata_hold", rdat[0], 32'hDEAD_BEEF);
    // A write response returns zero read data
    req(0, WRITE, 32'h14, 4'b1111, 32'h0102_0304, 32'h0, 1'b0);

    // LATENCY=4: byte-lane merge and masked reads
    req(1, WRITE, 32'h40, 4'b1111, 32'hAABB_CCDD, 32'h0, 1'b0);
    req(1, WRITE, 32'h40, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
    req(1, READ,  32'h40, 4'b1111, 32'h0, 32'hAA22_CC44, 1'b0);
    req(1, READ,  32'h40, 4'b0011, 32'h0, 32'h0000_CC44, 1'b0);
    req(1, WRITE, 32'h40, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    req(1, READ,  32'h40, 4'b0000, 32'h0, 32'h0, 1'b0);
    req(1, READ,  32'h40, 4'b1100, 32'h0, 32'hAA22_0000, 1'b0);

    // LATENCY=3: enable drop / address change mid-request
    req(2, WRITE, 32'h20, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
    req(2, READ,  32'h20, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);

    // Reset while BUSY: request discarded, store untouched
    en[2] = ENABLE; st[2] = WRITE; addr[2] = 32'h20; mask[2] = 4'b1111; wdat[2] = 32'hCAFE_F00D;
    @(negedge clk);
    en[2] = DISABLE;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_busy_ready", 32'(rdy[2]), 32'd0);
    end
    chk("rst_rdata", rdat[0], 32'd0);
    req(2, READ, 32'h20, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);

    // Range handling
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    req(0, WRITE, 32'h0,    4'b1111, 32'h0F0F_0F0F, 32'h0, 1'b0);
    req(0, READ,  32'h1000, 4'b1111, 32'h0, 32'h0, 1'b1);
    req(0, WRITE, 32'h1000, 4'b1111, 32'h55AA_55AA, 32'h0, 1'b1);
    req(0, READ,  32'h0,    4'b1111, 32'h0, 32'h0F0F_0F0F, 1'b0);
`else
    req(0, WRITE, 32'h1000, 4'b1111, 32'h55AA_55AA, 32'h0, 1'b0);
    req(0, READ,  32'h0,    4'b1111, 32'h0, 32'h55AA_55AA, 1'b0);
    req(0, READ,  32'hFFFF_F010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
`endif

    // Back-to-back with enable held: LATENCY=2 gives a ready every 3 cycles
    req(3, WRITE, 32'h30, 4'b1111, 32'h0BAD_CAFE, 32'h0, 1'b0);
    en[3] = ENABLE; st[3] = READ; addr[3] = 32'h30; mask[3] = 4'b1111; wdat[3] = '0;
    push_exp(3, 32'h0BAD_CAFE, 1'b0, cyc + 2);
    push_exp(3, 32'h0BAD_CAFE, 1'b0, cyc + 5);
    push_exp(3, 32'h0BAD_CAFE, 1'b0, cyc + 8);
    repeat (7) @(negedge clk);
    en[3] = DISABLE;
    wait_drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=%0d", cyc, 0);
    $fatal(1, "simulation time limit reached");
  end

endmodule
